// File: rtl/uart_tx_mmio_if.sv
// rtl/uart_tx_mmio_if.sv - MEM-stage data bus bundle for the memory-mapped UART transmitter
// Purpose: carries the processor's load/store strobes, address and data to one responder.
// Signals: MemRd, MemWr (strobes), Addr (byte address), WriteData (store data) driven by the
//          master; ReadData (combinational load data, 0 when not selected) driven by the slave.
interface uart_tx_mmio_if;
  logic        MemRd;
  logic        MemWr;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  modport master (output MemRd, MemWr, Addr, WriteData, input ReadData);
  modport slave  (input MemRd, MemWr, Addr, WriteData, output ReadData);
endinterface

// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - memory-mapped 8N1 UART transmitter with 4-entry TX FIFO and done interrupt
// Purpose: stores to TXDATA queue bytes; a serializer drains them onto UART_TX LSB first.
//          Registers: TXDATA +0, STATUS +4, CTRL +8, BAUDDIV +C relative to BASE_ADDR.
// Ports:
//   clk     - sole clock, all state on posedge
//   reset   - synchronous, active-high
//   bus     - data bus slave (MemRd, MemWr, Addr, WriteData in; ReadData out)
//   UART_TX - registered serial line, idle high
//   tx_irq  - registered done_pending AND irq_en
module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0030,
  parameter logic [15:0] DIV_RESET = 16'd5208
) (
  input  logic          clk,
  input  logic          reset,
  uart_tx_mmio_if.slave bus,
  output logic          UART_TX,
  output logic          tx_irq
);
  localparam logic [31:0] ADDR_TXDATA = BASE_ADDR;
  localparam logic [31:0] ADDR_STATUS = BASE_ADDR + 32'd4;
  localparam logic [31:0] ADDR_CTRL   = BASE_ADDR + 32'd8;
  localparam logic [31:0] ADDR_BAUD   = BASE_ADDR + 32'd12;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state, state_d;
  logic [15:0] div;
  logic [15:0] baud_cnt, baud_cnt_d;
  logic [2:0]  bit_idx, bit_idx_d;
  logic [7:0]  shift, shift_d;
  logic [7:0]  fifo_mem [4];
  logic [1:0]  wr_ptr, rd_ptr;
  logic [2:0]  count;
  logic        ovf, done_pending, irq_en;
  logic        fifo_empty, fifo_full;
  logic        wr_txdata, wr_status, wr_ctrl, wr_baud;
  logic        push, pop, drop, done_set, done_d, irq_en_d, bit_end, tx_d;

  assign wr_txdata = bus.MemWr && (bus.Addr == ADDR_TXDATA);
  assign wr_status = bus.MemWr && (bus.Addr == ADDR_STATUS);
  assign wr_ctrl   = bus.MemWr && (bus.Addr == ADDR_CTRL);
  assign wr_baud   = bus.MemWr && (bus.Addr == ADDR_BAUD);

  assign fifo_empty = (count == 3'd0);
  assign fifo_full  = (count == 3'd4);
  assign bit_end    = (baud_cnt == 16'd0);

  // A full FIFO still takes a store when the serializer pops on the same edge.
  assign push = wr_txdata && (!fifo_full || pop);
  assign drop = wr_txdata && fifo_full && !pop;

  // A completing frame beats a software clear on the same edge.
  assign done_d   = done_set || (done_pending && !(wr_status && bus.WriteData[1]));
  assign irq_en_d = wr_ctrl ? bus.WriteData[0] : irq_en;

  // Baud counter reloads only at bit boundaries, so a new BAUDDIV never
  // stretches or shortens the bit currently on the line.
  always_comb begin
    state_d    = state;
    baud_cnt_d = baud_cnt;
    bit_idx_d  = bit_idx;
    shift_d    = shift;
    pop        = 1'b0;
    done_set   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_d    = fifo_mem[rd_ptr];
          baud_cnt_d = div - 16'd1;
          state_d    = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_d    = DATA;
          bit_idx_d  = 3'd0;
          baud_cnt_d = div - 16'd1;
        end else begin
          baud_cnt_d = baud_cnt - 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_cnt_d = div - 16'd1;
          if (bit_idx == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx + 3'd1;
            shift_d   = {1'b0, shift[7:1]};
          end
        end else begin
          baud_cnt_d = baud_cnt - 16'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          done_set = 1'b1;
          if (!fifo_empty) begin
            // Chain straight into the next start bit: no idle gap between frames.
            pop        = 1'b1;
            shift_d    = fifo_mem[rd_ptr];
            baud_cnt_d = div - 16'd1;
            state_d    = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_cnt_d = baud_cnt - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level is registered from the next state so it changes with the state.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      baud_cnt     <= '0;
      bit_idx      <= '0;
      shift        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      ovf          <= 1'b0;
      done_pending <= 1'b0;
      irq_en       <= 1'b0;
      div          <= DIV_RESET;
      UART_TX      <= 1'b1;
      tx_irq       <= 1'b0;
    end else begin
      state        <= state_d;
      baud_cnt     <= baud_cnt_d;
      bit_idx      <= bit_idx_d;
      shift        <= shift_d;
      UART_TX      <= tx_d;
      done_pending <= done_d;
      irq_en       <= irq_en_d;
      tx_irq       <= done_d && irq_en_d;
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      if (push && !pop)      count <= count + 3'd1;
      else if (pop && !push) count <= count - 3'd1;
      if (drop)                                ovf <= 1'b1;
      else if (wr_status && bus.WriteData[4])  ovf <= 1'b0;
      if (wr_baud) div <= (bus.WriteData[15:0] < 16'd2) ? 16'd2 : bus.WriteData[15:0];
    end
  end

  // FIFO payload needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.WriteData[7:0];
  end

  // Read mux is zero when not selected so several responders can be OR-ed.
  always_comb begin
    bus.ReadData = '0;
    if (bus.MemRd) begin
      if (bus.Addr == ADDR_STATUS)
        bus.ReadData = {24'd0, count, ovf, fifo_empty, fifo_full, done_pending, (state != IDLE)};
      else if (bus.Addr == ADDR_CTRL)
        bus.ReadData = {31'd0, irq_en};
      else if (bus.Addr == ADDR_BAUD)
        bus.ReadData = {16'd0, div};
    end
  end
endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter that responds to the processor's MEM-stage data bus (MemRd/MemWr, 32-bit address, write data, combinational read data). It sits beside the existing peripherals in the 0x4000_xxxx space. Stores push bytes into a 4-entry TX FIFO, and an 8N1 serializer drains the FIFO onto `UART_TX`. A maskable transmit-done interrupt feeds the processor's interrupt logic.

## Interface
- `BASE_ADDR`, default 32'h40000030: word address of TXDATA. STATUS is at +4, CTRL at +8, BAUDDIV at +C.
- `DIV_RESET`, default 16'd5208: clocks per bit after reset.
- `clk` input, 1 bit: sole clock; all state updates on posedge.
- `reset` input, 1 bit: synchronous, active-high.
- `MemRd` input, 1 bit: read strobe, qualified by `Addr`.
- `MemWr` input, 1 bit: write strobe, qualified by `Addr`; takes effect at the posedge.
- `Addr` input, 32 bits: byte address; full 32-bit compare, no partial decode.
- `WriteData` input, 32 bits: store data.
- `ReadData` output, 32 bits: combinational; 0 unless `MemRd` is high and `Addr` hits a register. This allows OR-combining with other responders.
- `UART_TX` output, 1 bit: serial line, registered, idle high.
- `tx_irq` output, 1 bit: registered; equals done_pending AND irq_en.

## Operation
- **TXDATA (+0)**
  - Write pushes `WriteData[7:0]`.
  - If the FIFO is full, the byte is dropped and sticky `ovf` is set.
  - Reads return 0.
- **STATUS (+4)**, read value:
  - {24'd0, count[2:0], ovf, empty, full, done_pending, busy}.
  - busy = FSM not IDLE.
  - count ranges 0..4.
  - Write: `WriteData[1]`=1 clears done_pending; `WriteData[4]`=1 clears ovf. Other bits are ignored.
- **CTRL (+8)**: bit0 = irq_en. Read/write. Other bits read 0.
- **BAUDDIV (+C)**
  - 16-bit, read/write; upper bits read 0.
  - Written values below 2 are stored as 2.
  - A new value is applied at the next bit boundary, never mid-bit.
- **FIFO**
  - Depth 4; 2-bit read/write pointers that wrap; 3-bit count.
  - When full, a push and pop in the same cycle are both accepted and count stays at 4.
  - When empty, a push and pop in the same cycle cannot occur, because the pop requires not-empty in the prior cycle.
- **FSM states**: IDLE, START, DATA, STOP.
  - IDLE: if FIFO not empty, pop into the shift register, load the baud counter with div-1, and go to START. `UART_TX`=1.
  - START: `UART_TX`=0 for div clocks, then go to DATA with bit index 0.
  - DATA: `UART_TX`=shift[0] for div clocks per bit, LSB first. After bit 7, go to STOP.
  - STOP: `UART_TX`=1 for div clocks. At the terminal count, set done_pending.
    - FIFO not empty: pop and go directly to START (no idle gap).
    - FIFO empty: go to IDLE.
- **Interrupt**
  - If a done_pending set and a STATUS clear happen in the same cycle, set wins.
  - irq_en=0 masks `tx_irq` but does not clear done_pending.
- **Reset:** aborts any frame in progress and returns all state to its reset values (listed under Timing) at that edge.

## Timing
- Reset values:
  - `UART_TX`=1, `tx_irq`=0.
  - FIFO empty, pointers and count 0, ovf=0, done_pending=0, irq_en=0.
  - div=`DIV_RESET`, state IDLE.
  - `ReadData` is combinational; 0 when not selected.
- Register writes are visible to reads in the cycle after the write edge.
- **Latency with FSM idle:** write to TXDATA at edge E0.
  - Count=1 from E0.
  - At E1, pop; START begins and `UART_TX`=0 after E1.
- Frame length: exactly 10·div clocks from the start-bit falling edge to the end of the stop bit.
- done_pending, and `tx_irq` if enabled, assert after the edge that ends the stop bit.
- Back-to-back bytes: the next start bit begins on the edge after the last stop-bit clock, i.e. a continuous 10·div-clock cadence.
- Reset asserted mid-frame: `UART_TX`=1 after that edge; a partial frame is not resumed.

## Test plan
- Reset, then read all four registers: STATUS=32'h0000_0008 (empty), CTRL=0, BAUDDIV=5208, `UART_TX`=1, and `ReadData`=0 with `MemRd`=0.
- DIV_RESET=4; write 8'hA5 to TXDATA. Required:
  - `UART_TX`=0 for 4 clocks starting one edge after the write.
  - Then bits 1,0,1,0,0,1,0,1 at 4 clocks each, then stop=1.
  - done_pending=1 at clock 40 after start.
- DIV_RESET=4; five writes in consecutive cycles with the FSM idle. Required:
  - First byte popped immediately, so all five are accepted and ovf=0.
  - Then a sixth and seventh write with the FIFO full: ovf=1 and count stays 4.
  - Four queued frames go out back-to-back with no idle gap.
- Set irq_en=1 and send one byte: `tx_irq`=1 after the stop bit.
- Write STATUS=32'h2 in the same cycle that a second frame's stop bit ends: pending stays 1 (set wins).
- Write BAUDDIV=1 mid-DATA: the current bit keeps its old width, and later bits are 2 clocks wide. Assert reset mid-frame: `UART_TX`=1 and STATUS=8 on the next cycle.
